// File: rtl/matrix_calc_engine.sv
// rtl/matrix_calc_engine.sv - DIM x DIM matrix load / compute / show engine
module matrix_calc_engine #(
  parameter int DIM  = 2,
  parameter int DW   = 4,
  parameter int RW   = 10,
  parameter int IDXW = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [DW-1:0]   data_in,
  input  logic            enter,
  input  logic            sw,
  input  logic [1:0]      operation,
  output logic [RW-1:0]   data_out,
  output logic            finish,
  output logic            error,
  output logic [IDXW-1:0] index,
  output logic            busy
);

  // Row/column counters only need to reach DIM-1 (DIM is 2..4).
  localparam int CDW = (DIM > 2) ? 2 : 1;
  // Accumulator holds a full dot product; it is also wide enough to see RW overflow.
  localparam int AW  = 2 * DW + 2;
  localparam int CW  = (AW > RW + 1) ? AW : RW + 1;
  localparam logic [CDW-1:0] LAST = CDW'(DIM - 1);
  localparam logic [CW-1:0]  RMAX = {{(CW - RW){1'b0}}, {RW{1'b1}}};

  typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, COMPUTE = 2'd2, SHOW = 2'd3} state_t;

  state_t state, state_nxt;

  logic [DW-1:0] a_mem [DIM][DIM];
  logic [DW-1:0] b_mem [DIM][DIM];
  logic [RW-1:0] r_mem [DIM][DIM];

  logic           enter_q, sw_q;
  logic           enter_rise, sw_rise;
  logic [1:0]     op_q;
  logic [CDW-1:0] ri, cj, kk;
  logic [CDW-1:0] ri_step, cj_step;
  logic [IDXW-1:0] idx_step;
  logic           last_elem, elem_done;
  logic [CW-1:0]  acc, acc_nxt, prod, wide;
  logic [RW-1:0]  res;
  logic           sat;

  assign enter_rise = enter & ~enter_q;
  assign sw_rise    = sw & ~sw_q;
  assign last_elem  = (ri == LAST) && (cj == LAST);
  assign elem_done  = (op_q != 2'b10) || (kk == LAST);
  assign data_out   = finish ? r_mem[ri][cj] : '0;

  // Row-major advance of the element pointer, wrapping after the last element.
  always_comb begin
    cj_step  = (cj == LAST) ? '0 : cj + CDW'(1);
    ri_step  = (cj != LAST) ? ri : ((ri == LAST) ? '0 : ri + CDW'(1));
    idx_step = last_elem ? '0 : index + IDXW'(1);
  end

  // Result element for the current pointer; multiply uses one MAC step per cycle.
  always_comb begin
    prod    = CW'(a_mem[ri][kk]) * CW'(b_mem[kk][cj]);
    acc_nxt = ((kk == '0) ? '0 : acc) + prod;
    wide    = '0;
    res     = '0;
    sat     = 1'b0;
    case (op_q)
      2'b00:   wide = CW'(a_mem[ri][cj]) + CW'(b_mem[ri][cj]);
      2'b10:   wide = acc_nxt;
      default: wide = '0;
    endcase
    case (op_q)
      2'b01: res = {{(RW - DW){1'b0}}, a_mem[ri][cj]} - {{(RW - DW){1'b0}}, b_mem[ri][cj]};
      2'b11: res = {{(RW - DW){1'b0}}, a_mem[cj][ri]};
      default: begin
        sat = (wide > RMAX);
        res = sat ? RMAX[RW-1:0] : wide[RW-1:0];
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LOAD_A;
    else       state <= state_nxt;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    finish    = 1'b0;
    case (state)
      LOAD_A:  if (enter_rise && last_elem) state_nxt = (op_q == 2'b11) ? COMPUTE : LOAD_B;
      LOAD_B:  if (enter_rise && last_elem) state_nxt = COMPUTE;
      COMPUTE: begin
        busy = 1'b1;
        if (elem_done && last_elem) state_nxt = SHOW;
      end
      SHOW: begin
        finish = 1'b1;
        if (enter_rise) state_nxt = LOAD_A;
      end
    endcase
  end

  // Matrix storage, pointers, MAC accumulator and sticky error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enter_q <= 1'b0;
      sw_q    <= 1'b0;
      op_q    <= 2'b00;
      ri      <= '0;
      cj      <= '0;
      kk      <= '0;
      index   <= '0;
      acc     <= '0;
      error   <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
          r_mem[i][j] <= '0;
        end
      end
    end else begin
      enter_q <= enter;
      sw_q    <= sw;
      case (state)
        LOAD_A: if (enter_rise) begin
          a_mem[ri][cj] <= data_in;
          if (index == '0) op_q <= operation;
          ri    <= ri_step;
          cj    <= cj_step;
          index <= idx_step;
        end
        LOAD_B: if (enter_rise) begin
          b_mem[ri][cj] <= data_in;
          ri    <= ri_step;
          cj    <= cj_step;
          index <= idx_step;
        end
        COMPUTE: begin
          if (!elem_done) begin
            acc <= acc_nxt;
            kk  <= kk + CDW'(1);
          end else begin
            kk            <= '0;
            r_mem[ri][cj] <= res;
            if (sat) error <= 1'b1;
            ri    <= ri_step;
            cj    <= cj_step;
            index <= idx_step;
          end
        end
        SHOW: begin
          if (enter_rise) begin
            ri    <= '0;
            cj    <= '0;
            index <= '0;
            error <= 1'b0;
          end else if (sw_rise) begin
            ri    <= ri_step;
            cj    <= cj_step;
            index <= idx_step;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_calc_engine.sv
// tb/tb_matrix_calc_engine.sv - randomized self-checking bench for matrix_calc_engine
module tb_matrix_calc_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data_in = '0;
  logic       enter = 1'b0;
  logic       sw = 1'b0;
  logic [1:0] operation = '0;

  logic [9:0] data_out10;
  logic [7:0] data_out8;
  logic       finish10, finish8, error10, error8, busy10, busy8;
  logic [3:0] index10, index8;

  int n_vec = 0;
  int n_bad = 0;
  int ma[4];
  int mb[4];
  int e10[4];
  int e8[4];
  bit err10, err8;

  always #5 clock = ~clock;

  matrix_calc_engine #(.DIM(2), .DW(4), .RW(10), .IDXW(4)) u_dut10 (
    .clock(clock), .reset(reset), .data_in(data_in), .enter(enter), .sw(sw),
    .operation(operation), .data_out(data_out10), .finish(finish10),
    .error(error10), .index(index10), .busy(busy10)
  );

  matrix_calc_engine #(.DIM(2), .DW(4), .RW(8), .IDXW(4)) u_dut8 (
    .clock(clock), .reset(reset), .data_in(data_in), .enter(enter), .sw(sw),
    .operation(operation), .data_out(data_out8), .finish(finish8),
    .error(error8), .index(index8), .busy(busy8)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Unsaturated mathematical result for element e (row-major, 2x2).
  function automatic int true_val(input int op, input int e);
    int i, j;
    i = e / 2;
    j = e % 2;
    case (op)
      0:       return ma[e] + mb[e];
      1:       return ma[e] - mb[e];
      2:       return ma[i*2] * mb[j] + ma[i*2+1] * mb[2+j];
      default: return ma[j*2+i];
    endcase
  endfunction

  task automatic build_expect(input int op);
    int tv;
    err10 = 0;
    err8  = 0;
    for (int e = 0; e < 4; e++) begin
      tv = true_val(op, e);
      if (op == 1) begin
        e10[e] = tv & 1023;
        e8[e]  = tv & 255;
      end else begin
        e10[e] = (tv > 1023) ? 1023 : tv;
        e8[e]  = (tv > 255) ? 255 : tv;
        if (tv > 1023) err10 = 1;
        if (tv > 255)  err8  = 1;
      end
    end
  endtask

  task automatic press_enter(input int v, input bit last);
    data_in = 4'(v);
    enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
    if (!last) @(negedge clock);
  endtask

  task automatic press_sw();
    sw = 1'b1;
    @(negedge clock);
    sw = 1'b0;
    @(negedge clock);
  endtask

  task automatic run_op(input int op, input bit both_exit);
    int cnt;
    operation = 2'(op);
    press_sw();
    chk("sw_ignored_in_load", index10, 0);
    for (int e = 0; e < 4; e++) begin
      press_enter(ma[e], (op == 3) && (e == 3));
      if (e == 0) operation = 2'($urandom_range(0, 3));
    end
    if (op != 3) begin
      chk("load_data_out_zero", data_out10, 0);
      chk("load_finish_low", finish10, 0);
      for (int e = 0; e < 4; e++) press_enter(mb[e], e == 3);
    end
    build_expect(op);
    cnt = 0;
    while (busy10 && cnt < 300) begin
      cnt++;
      @(negedge clock);
    end
    chk("busy_cycles", cnt, (op == 2) ? 8 : 4);
    chk("busy_cycles_rw8", busy8, 0);
    chk("finish_high", finish10, 1);
    chk("finish_high_rw8", finish8, 1);
    for (int e = 0; e < 4; e++) begin
      chk("show_index", index10, e);
      chk("show_data_rw10", data_out10, e10[e]);
      chk("show_data_rw8", data_out8, e8[e]);
      press_sw();
    end
    chk("wrap_index", index10, 0);
    chk("wrap_data", data_out10, e10[0]);
    chk("error_rw10", error10, err10);
    chk("error_rw8", error8, err8);
    enter = 1'b1;
    sw = both_exit;
    @(negedge clock);
    chk("exit_finish", finish8, 0);
    chk("exit_error", error8, 0);
    chk("exit_index", index10, 0);
    chk("exit_data_out", data_out10, 0);
    chk("exit_busy", busy10, 0);
    enter = 1'b0;
    sw = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_data_out", data_out10, 0);
    chk("rst_finish", finish10, 0);
    chk("rst_error", error10, 0);
    chk("rst_index", index10, 0);
    chk("rst_busy", busy10, 0);
    reset = 1'b0;
    @(negedge clock);

    // Held enter level loads a single element.
    operation = 2'b00;
    data_in = 4'd9;
    enter = 1'b1;
    repeat (10) @(negedge clock);
    chk("hold_index", index10, 1);
    chk("hold_busy", busy10, 0);
    enter = 1'b0;
    @(negedge clock);
    for (int e = 0; e < 3; e++) press_enter(e + 1, 0);
    press_enter(5, 0);
    chk("loadb_index", index10, 1);

    // Asynchronous reset in the middle of LOAD_B.
    #1 reset = 1'b1;
    #1;
    chk("midrst_index", index10, 0);
    chk("midrst_finish", finish10, 0);
    chk("midrst_busy", busy10, 0);
    chk("midrst_error", error10, 0);
    chk("midrst_data_out", data_out10, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    ma = '{1, 2, 3, 4}; mb = '{5, 6, 7, 8};
    run_op(0, 0);
    mb = '{2, 2, 2, 2};
    run_op(1, 0);
    mb = '{5, 6, 7, 8};
    run_op(2, 0);
    ma = '{15, 15, 15, 15}; mb = '{15, 15, 15, 15};
    run_op(2, 0);
    ma = '{1, 2, 3, 4};
    run_op(3, 1);

    for (int t = 0; t < 8; t++) begin
      for (int e = 0; e < 4; e++) begin
        ma[e] = (t[0]) ? 15 - int'($urandom_range(0, 2)) : int'($urandom_range(0, 15));
        mb[e] = int'($urandom_range(0, 15));
      end
      run_op(int'($urandom_range(0, 3)), t[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_calc_engine.md
Name: matrix_calc_engine

Overview:
- Parametrised successor to the fixed 2x2 matrix calculator core. The user loads square matrices A and B element by element, selects an operation, and steps through the result one element at a time.
- Sits behind the chip-level synchronizers: all inputs arrive already synchronised to clock.
- Adds over the previous generation: configurable dimension and widths, a sequential MAC-based multiply, transpose, saturation with error reporting, and a busy indication.

Parameters:
- DIM, 2, matrix dimension (DIM x DIM); legal range 2..4.
- DW, 4, unsigned input element width.
- RW, 10, result element width; must satisfy RW >= DW+1.
- IDXW, 4, index output width; must satisfy 2^IDXW >= DIM*DIM.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DW  element value presented with enter.
- enter  input  1  level signal; each rising edge accepts one action.
- sw  input  1  level signal; each rising edge steps the result display.
- operation  input  2  operation select: 00 A+B, 01 A-B, 10 AxB, 11 transpose(A).
- data_out  output  RW  result element at index; 0 outside SHOW.
- finish  output  1  high while in SHOW.
- error  output  1  sticky; set when any result element saturated.
- index  output  IDXW  current element position, row-major.
- busy  output  1  high while in COMPUTE.

Behaviour:
- Reset values: state LOAD_A; all outputs 0; A, B and R storage cleared.
- Edge detection: enter and sw are registered internally; an edge is prev==0 and now==1. A held level counts as exactly one edge.
- LOAD_A:
  - Each enter edge writes data_in to A[index], then increments index.
  - operation is latched on the first A entry of each load cycle.
  - After DIM*DIM entries, index returns to 0. Next state is COMPUTE if the latched op is 11, otherwise LOAD_B.
- LOAD_B:
  - Same as LOAD_A, writing B. Exits to COMPUTE after DIM*DIM entries.
- Load-state rules: sw edges are ignored in both load states; changes to operation after latching are ignored.
- COMPUTE:
  - busy=1; enter and sw are ignored.
  - Ops 00, 01 and 11 produce one result element per cycle, taking DIM*DIM cycles.
  - Op 10 runs a single MAC over DIM cycles per element, taking DIM^3 cycles.
  - On the cycle after the last element is written: finish=1, busy=0, state=SHOW, index=0.
- Arithmetic:
  - Add and multiply are unsigned. If a true result exceeds 2^RW-1, store 2^RW-1 and set error.
  - Multiply: saturation is checked on the final accumulated sum. The accumulator is at least 2*DW+2 bits wide internally.
  - Subtract: RW-bit two's complement, with operands zero-extended; it never saturates.
  - Transpose: R[i][j]=A[j][i], zero-extended to RW.
- SHOW:
  - data_out=R[index], combinational from index.
  - Each sw edge increments index; it wraps from DIM*DIM-1 back to 0.
  - An enter edge returns to LOAD_A: index=0, finish=0, error=0, data_out=0. No element is written on that edge.
- Simultaneous enter and sw edges: enter wins; sw is dropped.
- Reset mid-operation: immediate return to reset values, including mid-COMPUTE. Any partially loaded matrix is discarded.

Test Plan:
- DIM=2, op 00, A=1,2,3,4, B=5,6,7,8 -> busy for exactly 4 cycles, then finish=1. sw steps show 6,8,10,12, then wrap to 6 with index=0.
- Op 01, A=1,2,3,4, B=2,2,2,2 -> data_out shows 0x3FF,0,1,2; error=0.
- Op 10, A=1,2,3,4, B=5,6,7,8 -> finish rises exactly 8 cycles after entering COMPUTE; results 19,22,43,50.
- RW=8, op 10, A and B all 15 -> every element is 255 (true value 450); error=1. A subsequent enter edge clears error and finish.
- Op 11, A=1,2,3,4 -> the 4th enter edge goes directly to COMPUTE with no B load; results 1,3,2,4.
- Mixed input and reset checks:
  - enter held high for 10 cycles loads exactly one element.
  - Simultaneous enter and sw edges in SHOW -> returns to LOAD_A.
  - reset asserted mid-LOAD_B -> all outputs 0 in the same cycle, index=0.
